// File: rtl/bcd_ascii_pkg.sv
// Shared types, ASCII constants and digit encoding for the BCD-to-ASCII serializer.
// BCD_ASCII_TX_CRLF_EN adds the CR/LF trailer states.
package bcd_ascii_pkg;

`ifdef BCD_ASCII_TX_CRLF_EN
    typedef enum logic [1:0] {S_IDLE, S_DIG, S_CR, S_LF} state_t;
`else
    typedef enum logic {S_IDLE, S_DIG} state_t;
`endif

    localparam logic [7:0] ZERO = 8'h30;
    localparam logic [7:0] ERR  = 8'h3F;
    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;

    // Digits above 9 are not valid BCD and are flagged with '?'.
    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        if (d <= 4'd9)
            return ZERO + {4'h0, d};
        else
            return ERR;
    endfunction

endpackage

// File: rtl/bcd_ascii_tx_lead.sv
// Priority encoder: position of the most significant nonzero BCD digit (0 when all zero).
module bcd_lead_idx #(
    parameter int DEC_W = 8,
    parameter int IW    = (DEC_W > 1) ? $clog2(DEC_W) : 1
) (
    input  logic [DEC_W-1:0][3:0] digits,
    output logic [IW-1:0]         index
);

    // Ascending scan: the highest nonzero digit is the last to write.
    always_comb begin
        index = '0;
        for (int unsigned i = 0; i < DEC_W; i++) begin
            if (digits[i] != 4'h0)
                index = IW'(i);
        end
    end

endmodule

// File: rtl/bcd_ascii_tx.sv
// Serializes packed BCD digits into an ASCII byte stream, leading zeros suppressed.
// Define BCD_ASCII_TX_CRLF_EN to terminate each string with CR LF.
module bcd_ascii_tx
    import bcd_ascii_pkg::*;
#(
    parameter int DEC_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DEC_W-1:0][3:0] bcd,
    input  logic                 start,
    output logic                 rdy,
    output logic [7:0]           m_dat,
    output logic                 m_val,
    input  logic                 m_rdy,
    output logic                 m_last
);

    localparam int IW = (DEC_W > 1) ? $clog2(DEC_W) : 1;

    state_t                  state, state_n;
    logic [DEC_W-1:0][3:0]   bcd_q, bcd_n;
    logic [IW-1:0]           idx, idx_n;
    logic [IW-1:0]           lead;

    bcd_lead_idx #(
        .DEC_W (DEC_W),
        .IW    (IW)
    ) u_lead (
        .digits (bcd),
        .index  (lead)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            bcd_q <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            bcd_q <= bcd_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        bcd_n   = bcd_q;
        idx_n   = idx;
        rdy     = 1'b0;
        m_val   = 1'b0;
        m_last  = 1'b0;
        m_dat   = 8'h00;
        case (state)
            S_IDLE: begin
                rdy = 1'b1;
                if (start) begin
                    state_n = S_DIG;
                    bcd_n   = bcd;
                    idx_n   = lead;
                end
            end
            S_DIG: begin
                m_val = 1'b1;
                m_dat = digit_ascii(bcd_q[idx]);
`ifdef BCD_ASCII_TX_CRLF_EN
                m_last = 1'b0;
`else
                m_last = (idx == '0);
`endif
                if (m_rdy) begin
                    if (idx != '0) begin
                        idx_n = idx - IW'(1);
                    end else begin
`ifdef BCD_ASCII_TX_CRLF_EN
                        state_n = S_CR;
`else
                        state_n = S_IDLE;
`endif
                    end
                end
            end
`ifdef BCD_ASCII_TX_CRLF_EN
            S_CR: begin
                m_val = 1'b1;
                m_dat = CR;
                if (m_rdy)
                    state_n = S_LF;
            end
            S_LF: begin
                m_val  = 1'b1;
                m_last = 1'b1;
                m_dat  = LF;
                if (m_rdy)
                    state_n = S_IDLE;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bcd_ascii_tx.sv
// Directed, table-driven bench for bcd_ascii_tx with DEC_W=4.
module tb_bcd_ascii_tx;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0][3:0]   bcd;
    logic              start;
    logic              rdy;
    logic [7:0]        m_dat;
    logic              m_val;
    logic              m_rdy;
    logic              m_last;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_ascii_tx #(.DEC_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bcd    (bcd),
        .start  (start),
        .rdy    (rdy),
        .m_dat  (m_dat),
        .m_val  (m_val),
        .m_rdy  (m_rdy),
        .m_last (m_last)
    );

    typedef struct {
        logic [15:0] bcd;
        bit          tog;   // m_rdy pattern 1010... instead of constant 1
        bit          inj;   // pulse start with 0x1234 mid-string
        int          n;     // digit beats
        logic [31:0] exp;   // first beat in bits [31:24]
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0]  ex[$];
        logic [31:0] e;
        logic [7:0]  held;
        bit          stalled;
        int          beat;
        int          cyc;
        e = v.exp;
        for (int k = 0; k < v.n; k++)
            ex.push_back(e[31-8*k -: 8]);
`ifdef BCD_ASCII_TX_CRLF_EN
        ex.push_back(8'h0D);
        ex.push_back(8'h0A);
`endif
        cyc = 0;
        while (!rdy && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        chk("idle_before_start", {31'b0, rdy}, 32'd1);
        bcd   = v.bcd;
        start = 1'b1;
        m_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_val_latency", {31'b0, m_val}, 32'd1);
        chk("rdy_low_busy", {31'b0, rdy}, 32'd0);
        beat = 0;
        cyc = 0;
        stalled = 1'b0;
        while (beat < ex.size() && cyc < 200) begin
            if (stalled) begin
                chk("stall_hold_dat", {24'b0, m_dat}, {24'b0, held});
                chk("stall_hold_val", {31'b0, m_val}, 32'd1);
            end
            if (v.inj) begin
                start = (cyc == 1);
                if (cyc == 1)
                    bcd = 16'h1234;
            end
            m_rdy = v.tog ? (cyc % 2 == 0) : 1'b1;
            if (m_rdy) begin
                chk("beat_val", {31'b0, m_val}, 32'd1);
                chk("beat_dat", {24'b0, m_dat}, {24'b0, ex[beat]});
                chk("beat_last", {31'b0, m_last}, (beat == ex.size() - 1) ? 32'd1 : 32'd0);
                chk("beat_rdy_excl", {31'b0, rdy}, 32'd0);
                beat++;
                stalled = 1'b0;
            end else begin
                held = m_dat;
                stalled = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        m_rdy = 1'b1;
        chk("beats_complete", beat, ex.size());
        chk("done_rdy", {31'b0, rdy}, 32'd1);
        chk("done_val", {31'b0, m_val}, 32'd0);
        @(negedge clk);
        chk("no_extra_string", {31'b0, m_val}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'h0407, 1'b0, 1'b0, 3, 32'h34303700};
        vecs[1] = '{16'h0000, 1'b0, 1'b0, 1, 32'h30000000};
        vecs[2] = '{16'h9A21, 1'b1, 1'b0, 4, 32'h393F3231};
        vecs[3] = '{16'h5678, 1'b0, 1'b1, 4, 32'h35363738};
        vecs[4] = '{16'hFFFF, 1'b0, 1'b0, 4, 32'h3F3F3F3F};
        vecs[5] = '{16'h1000, 1'b0, 1'b0, 4, 32'h31303030};
        vecs[6] = '{16'h0B00, 1'b0, 1'b0, 3, 32'h3F303000};

        rst   = 1'b1;
        start = 1'b0;
        bcd   = '0;
        m_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_rdy", {31'b0, rdy}, 32'd1);
        chk("reset_val", {31'b0, m_val}, 32'd0);
        chk("reset_last", {31'b0, m_last}, 32'd0);
        chk("reset_dat", {24'b0, m_dat}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i]);

        // Abort mid-string: reset wins over a simultaneous start and handshake.
        bcd   = 16'h1234;
        start = 1'b1;
        m_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_beat0", {24'b0, m_dat}, 32'h31);
        @(negedge clk);
        chk("abort_beat1", {24'b0, m_dat}, 32'h32);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        bcd   = 16'h0005;
        @(negedge clk);
        chk("abort_val", {31'b0, m_val}, 32'd0);
        chk("abort_rdy", {31'b0, rdy}, 32'd1);
        chk("abort_dat", {24'b0, m_dat}, 32'h0);
        chk("abort_last", {31'b0, m_last}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("abort_no_resume", {31'b0, m_val}, 32'd0);
        run_vec('{16'h0009, 1'b0, 1'b0, 1, 32'h39000000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_ascii_tx.md
BCD_ASCII_TX -- requirements
Module: bcd_ascii_tx

Interface
REQ-001 SHALL have parameter DEC_W, default 8, number of BCD digits accepted per conversion.
REQ-002 SHALL have input clk, 1 bit, the clock; all logic is rising-edge.
REQ-003 SHALL have input rst, 1 bit, synchronous active-high reset.
REQ-004 SHALL have input bcd, [DEC_W-1:0][3:0], packed BCD digits; digit DEC_W-1 is most significant.
REQ-005 SHALL have input start, 1 bit, request to serialize bcd; sampled only while rdy=1.
REQ-006 SHALL have output rdy, 1 bit, idle and able to accept start.
REQ-007 SHALL have output m_dat, 8 bits, ASCII character of the current stream beat.
REQ-008 SHALL have output m_val, 1 bit, m_dat is valid.
REQ-009 SHALL have input m_rdy, 1 bit, downstream accepts the beat.
REQ-010 SHALL have output m_last, 1 bit, marks the final beat of a string.

Function
REQ-011 SHALL accept a request on the edge where start=1 and rdy=1, latching bcd and clearing rdy on that edge.
REQ-012 SHALL ignore start while rdy=0; latched digits do not change until the string completes.
REQ-013 SHALL compute the index of the most significant nonzero digit from bcd at acceptance (priority encode); if all digits are zero, the index is 0 (units digit).
REQ-014 SHALL assert m_val on the first edge after acceptance (one-cycle latency), presenting the digit at that index.
REQ-015 SHALL emit digits from the starting index down to digit 0, most significant first, one per handshake (m_val=1 and m_rdy=1).
REQ-016 SHALL encode digits 0-9 as 0x30+digit; digits 10-15 SHALL be encoded as 0x3F ('?').
REQ-017 SHALL hold m_dat, m_val and m_last stable while m_val=1 and m_rdy=0.
REQ-018 SHALL advance on each handshake with no bubble; back-to-back beats occur when m_rdy is held at 1.
REQ-019 SHALL assert m_last with the final beat; on that beat's handshake it SHALL deassert m_val and assert rdy on the same edge.
REQ-020 SHALL accept a new start in the cycle after rdy rises; rdy and m_val are never 1 simultaneously.
REQ-021 SHALL implement the FSM states IDLE (rdy=1), DIG (emitting digits), CR and LF (macro only); transitions: IDLE->DIG on accept; DIG->DIG on handshake with index>0; DIG->IDLE (or CR) on handshake at index 0; CR->LF and LF->IDLE on handshake.
REQ-022 SHALL hold the digit index in a counter of $clog2(DEC_W) bits minimum width (1 bit when DEC_W=1) that decrements without wrap-around.

Reset
REQ-023 SHALL, while rst=1, force state IDLE, rdy=1, m_val=0, m_last=0, m_dat=0x00 and the index to 0.
REQ-024 SHALL abort a string in progress on reset: m_val falls on the reset edge, and no partial string resumes afterwards.
REQ-025 SHALL give rst priority over start and over any handshake in the same cycle.

Configuration
REQ-026 SHALL, when BCD_ASCII_TX_CRLF_EN is defined, append 0x0D then 0x0A after digit 0, with m_last on the 0x0A beat only.
REQ-027 SHALL, when BCD_ASCII_TX_CRLF_EN is undefined, omit the CR/LF states entirely, with m_last on the digit-0 beat.

Structure
REQ-028 SHALL take from package bcd_ascii_pkg: the FSM state enum, ASCII constants (ZERO 0x30, ERR 0x3F, CR 0x0D, LF 0x0A) and a digit-to-ASCII function.
REQ-029 SHALL place the leading-digit priority encoder in sub-module bcd_lead_idx (parameter DEC_W; input digits; output index).
REQ-030 SHALL be stream-compatible downstream of bin2bcd: its out/rdy pair drives bcd/start directly.

Verification (DEC_W=4)
REQ-031 SHALL check: bcd=0x0407, start, m_rdy=1 -> beats 0x34,0x30,0x37, m_last on 0x37, first m_val one cycle after accept, rdy high again after 3 beats.
REQ-032 SHALL check: bcd=0x0000 -> single beat 0x30 with m_last=1; with macro: 0x30,0x0D,0x0A, m_last on 0x0A.
REQ-033 SHALL check: bcd=0x9A21, m_rdy toggling 1010... -> 0x39,0x3F,0x32,0x31; m_dat stable during every stall.
REQ-034 SHALL check: start pulsed with bcd=0x1234 mid-string of 0x5678 -> output is 0x35,0x36,0x37,0x38 only; the second request is dropped.
REQ-035 SHALL check: rst asserted after the second beat of 0x1234 -> m_val=0 and rdy=1 after the edge; a following start with 0x0009 yields the single beat 0x39.
